// File: rtl/softex_slot_cache.sv
// softex_slot_cache: per-row softmax partial-state cache (running max, running
// denominator) with hardware slot allocation, occupancy tracking and update
// error reporting. Requests see slot state as of the start of their cycle.
module softex_slot_cache #(
  parameter int N_SLOTS        = 8,
  parameter int SLOT_ADDR_BITS = 8,
  parameter int WIDTH_MAX      = 16,
  parameter int WIDTH_DEN      = 32
) (
  input  logic                           clk_i,
  input  logic                           rst_i,
  input  logic                           clear_i,
  input  logic                           req_valid_i,
  output logic                           req_ready_o,
  input  logic                           req_op_i,
  input  logic [SLOT_ADDR_BITS-1:0]      req_addr_i,
  output logic                           rsp_valid_o,
  input  logic                           rsp_ready_i,
  output logic                           rsp_hit_o,
  output logic [SLOT_ADDR_BITS-1:0]      rsp_addr_o,
  output logic [WIDTH_MAX-1:0]           rsp_max_o,
  output logic [WIDTH_DEN-1:0]           rsp_den_o,
  input  logic                           upd_valid_i,
  input  logic                           upd_op_i,
  input  logic [SLOT_ADDR_BITS-1:0]      upd_addr_i,
  input  logic [WIDTH_MAX-1:0]           upd_max_i,
  input  logic [WIDTH_DEN-1:0]           upd_den_i,
  output logic                           upd_err_o,
  output logic [$clog2(N_SLOTS+1)-1:0]   n_used_o,
  output logic                           full_o,
  output logic                           empty_o
);

  localparam int IDX_W = $clog2(N_SLOTS);
  localparam int CNT_W = $clog2(N_SLOTS+1);

  logic [N_SLOTS-1:0]        alloc_q, alloc_d, valid_q, valid_d;
  logic [WIDTH_MAX-1:0]      max_q [N_SLOTS];
  logic [WIDTH_MAX-1:0]      max_d [N_SLOTS];
  logic [WIDTH_DEN-1:0]      den_q [N_SLOTS];
  logic [WIDTH_DEN-1:0]      den_d [N_SLOTS];
  logic                      rsp_valid_q, rsp_valid_d, rsp_hit_q, rsp_hit_d;
  logic [SLOT_ADDR_BITS-1:0] rsp_addr_q, rsp_addr_d;
  logic [WIDTH_MAX-1:0]      rsp_max_q, rsp_max_d;
  logic [WIDTH_DEN-1:0]      rsp_den_q, rsp_den_d;
  logic                      upd_err_q, upd_err_d;
  logic [CNT_W-1:0]          n_used_q, n_used_d;
  logic                      full_q, full_d, empty_q, empty_d;

  logic             req_fire, req_in_range, upd_in_range, load_hit;
  logic             free_found, upd_ok, alloc_ok, free_ok;
  logic [IDX_W-1:0] free_idx, req_idx, upd_idx;

  assign req_ready_o  = !clear_i && (!rsp_valid_q || rsp_ready_i);
  assign req_fire     = req_valid_i && req_ready_o;
  assign req_idx      = req_addr_i[IDX_W-1:0];
  assign upd_idx      = upd_addr_i[IDX_W-1:0];
  assign req_in_range = 32'(req_addr_i) < N_SLOTS;
  assign upd_in_range = 32'(upd_addr_i) < N_SLOTS;
  assign load_hit     = req_in_range && valid_q[req_idx];
  assign free_found   = ~&alloc_q;
  // An update to a slot being allocated this cycle still sees alloc=0 and is rejected.
  assign upd_ok       = upd_valid_i && !clear_i && upd_in_range && alloc_q[upd_idx];
  assign alloc_ok     = req_fire && !req_op_i && free_found;
  assign free_ok      = upd_ok && upd_op_i;

  // Lowest-index free slot, searched on the pre-update alloc map.
  always_comb begin
    free_idx = '0;
    for (int i = N_SLOTS - 1; i >= 0; i--) begin
      if (!alloc_q[i]) free_idx = IDX_W'(i);
    end
  end

  // Slot state, occupancy and error pulse next-state.
  always_comb begin
    alloc_d = alloc_q;
    valid_d = valid_q;
    max_d   = max_q;
    den_d   = den_q;
    if (clear_i) begin
      alloc_d = '0;
      valid_d = '0;
    end else begin
      if (upd_ok) begin
        if (upd_op_i) begin
          alloc_d[upd_idx] = 1'b0;
          valid_d[upd_idx] = 1'b0;
        end else begin
          max_d[upd_idx]   = upd_max_i;
          den_d[upd_idx]   = upd_den_i;
          valid_d[upd_idx] = 1'b1;
        end
      end
      if (alloc_ok) begin
        alloc_d[free_idx] = 1'b1;
        valid_d[free_idx] = 1'b0;
      end
    end
    n_used_d  = clear_i ? '0 : n_used_q + CNT_W'(alloc_ok) - CNT_W'(free_ok);
    full_d    = (n_used_d == CNT_W'(N_SLOTS));
    empty_d   = (n_used_d == '0);
    upd_err_d = upd_valid_i && !clear_i && !upd_ok;
  end

  // Single-entry response register; fields hold while stalled.
  always_comb begin
    rsp_valid_d = rsp_valid_q;
    rsp_hit_d   = rsp_hit_q;
    rsp_addr_d  = rsp_addr_q;
    rsp_max_d   = rsp_max_q;
    rsp_den_d   = rsp_den_q;
    if (clear_i) begin
      rsp_valid_d = 1'b0;
    end else if (req_fire) begin
      rsp_valid_d = 1'b1;
      if (!req_op_i) begin
        rsp_hit_d  = free_found;
        rsp_addr_d = free_found ? SLOT_ADDR_BITS'(free_idx) : '0;
        rsp_max_d  = '0;
        rsp_den_d  = '0;
      end else begin
        rsp_hit_d  = load_hit;
        rsp_addr_d = req_addr_i;
        rsp_max_d  = load_hit ? max_q[req_idx] : '0;
        rsp_den_d  = load_hit ? den_q[req_idx] : '0;
      end
    end else if (rsp_ready_i) begin
      rsp_valid_d = 1'b0;
    end
  end

  // State registers with asynchronous reset.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      alloc_q     <= '0;
      valid_q     <= '0;
      for (int i = 0; i < N_SLOTS; i++) begin
        max_q[i] <= '0;
        den_q[i] <= '0;
      end
      rsp_valid_q <= 1'b0;
      rsp_hit_q   <= 1'b0;
      rsp_addr_q  <= '0;
      rsp_max_q   <= '0;
      rsp_den_q   <= '0;
      upd_err_q   <= 1'b0;
      n_used_q    <= '0;
      full_q      <= 1'b0;
      empty_q     <= 1'b1;
    end else begin
      alloc_q     <= alloc_d;
      valid_q     <= valid_d;
      max_q       <= max_d;
      den_q       <= den_d;
      rsp_valid_q <= rsp_valid_d;
      rsp_hit_q   <= rsp_hit_d;
      rsp_addr_q  <= rsp_addr_d;
      rsp_max_q   <= rsp_max_d;
      rsp_den_q   <= rsp_den_d;
      upd_err_q   <= upd_err_d;
      n_used_q    <= n_used_d;
      full_q      <= full_d;
      empty_q     <= empty_d;
    end
  end

  assign rsp_valid_o = rsp_valid_q;
  assign rsp_hit_o   = rsp_hit_q;
  assign rsp_addr_o  = rsp_addr_q;
  assign rsp_max_o   = rsp_max_q;
  assign rsp_den_o   = rsp_den_q;
  assign upd_err_o   = upd_err_q;
  assign n_used_o    = n_used_q;
  assign full_o      = full_q;
  assign empty_o     = empty_q;

endmodule

// File: doc/softex_slot_cache.md
# softex_slot_cache

Parametrised state cache for the softmax accelerator. It holds per-row partial softmax state (running maximum, running denominator) in `N_SLOTS` slots. Slot allocation is done in hardware: a free-slot search, occupancy tracking and error reporting replace software-managed slot addresses. It sits between the controller (which issues ALLOC/LOAD requests and UPDATE/FREE operations) and the datapath, which consumes the loaded maximum and denominator.

## Interface
- `N_SLOTS`, 8: number of slots, ≥2.
- `SLOT_ADDR_BITS`, 8: address width; must be ≥ $clog2(N_SLOTS).
- `WIDTH_MAX`, 16: maximum field width (FP16ALT).
- `WIDTH_DEN`, 32: denominator field width (FP32).
- `clk_i` in 1: clock.
- `rst_i` in 1: reset. One clock; asynchronous, active-high.
- `clear_i` in 1: synchronous flush of all slots.
- `req_valid_i` in 1 / `req_ready_o` out 1: request handshake.
- `req_op_i` in 1: 0=ALLOC, 1=LOAD.
- `req_addr_i` in SLOT_ADDR_BITS: slot address for LOAD; ignored for ALLOC.
- `rsp_valid_o` out 1 / `rsp_ready_i` in 1: response handshake.
- `rsp_hit_o` out 1: request succeeded.
- `rsp_addr_o` out SLOT_ADDR_BITS: allocated or loaded slot address.
- `rsp_max_o` out WIDTH_MAX, `rsp_den_o` out WIDTH_DEN: slot contents.
- `upd_valid_i` in 1: update strobe; always accepted.
- `upd_op_i` in 1: 0=UPDATE, 1=FREE.
- `upd_addr_i` in SLOT_ADDR_BITS: target slot.
- `upd_max_i` in WIDTH_MAX, `upd_den_i` in WIDTH_DEN: data for UPDATE.
- `upd_err_o` out 1: one-cycle pulse when an update is rejected.
- `n_used_o` out $clog2(N_SLOTS+1): number of allocated slots.
- `full_o`, `empty_o` out 1: n_used_o==N_SLOTS / n_used_o==0.

## Operation
- Per-slot state: `alloc` bit, `valid` bit, max register, den register.
- ALLOC:
  - Picks the lowest-index slot with alloc=0, sets alloc=1 and valid=0.
  - Response: hit=1, addr=index, max/den=0.
  - If all slots are allocated: hit=0, addr=0, no state change.
- LOAD:
  - If addr<N_SLOTS and valid=1: hit=1, addr echoed, stored max/den returned.
  - Otherwise: hit=0, max/den=0.
- UPDATE:
  - If addr<N_SLOTS and alloc=1: writes max/den and sets valid=1.
  - Otherwise: ignored, and upd_err_o pulses.
- FREE:
  - If addr<N_SLOTS and alloc=1: clears alloc and valid. Data registers are left unchanged.
  - Otherwise: ignored, and upd_err_o pulses.
- Read-before-write: a request accepted in cycle t sees slot state as of the start of t.
  - A same-cycle UPDATE or FREE takes effect from t+1.
  - LOAD concurrent with UPDATE to the same slot returns the old data and the old valid.
  - ALLOC concurrent with FREE of slot k cannot select k.
  - UPDATE to the slot being allocated in the same cycle is rejected (its alloc bit is still 0).
- n_used_o:
  - +1 on a successful ALLOC, −1 on a successful FREE.
  - Both in the same cycle: unchanged.
  - Never wraps: bounded by the alloc map.
- clear_i has highest priority:
  - All alloc/valid bits are cleared, n_used_o goes to 0 and rsp_valid_o goes to 0 (a pending response is dropped).
  - req_ready_o=0 in that cycle; the concurrent update is discarded without an error pulse.

## Timing
- Reset values:
  - rsp_valid_o=0; rsp_hit_o, rsp_addr_o, rsp_max_o, rsp_den_o=0.
  - upd_err_o=0, n_used_o=0, full_o=0, empty_o=1.
  - req_ready_o=1.
  - All slot bits and data registers = 0.
- Request latency: the request is accepted in cycle t (req_valid_i & req_ready_o); the response is registered and visible at t+1.
- Single-entry output register: req_ready_o = !clear_i & (!rsp_valid_o | rsp_ready_i), giving back-to-back throughput of 1/cycle.
- Response fields hold stable while rsp_valid_o & !rsp_ready_i.
- An update at cycle t is visible to requests accepted at t+1 or later. upd_err_o is asserted at t+1 for exactly one cycle.
- n_used_o, full_o and empty_o are registered and updated at t+1.
- Reset asserted mid-operation returns all state to the reset values immediately (asynchronous); an in-flight response is lost.

## Test plan
- After reset, 8 ALLOCs back-to-back with rsp_ready_i=1 -> responses addr 0..7, all hit=1; n_used_o reaches 8, full_o=1. A 9th ALLOC -> hit=0, addr=0, n_used_o stays 8.
- UPDATE slot 3 with max=16'h3F80, den=32'h40000000, then LOAD 3 -> hit=1, max=16'h3F80, den=32'h40000000. LOAD 4 (allocated, never updated) -> hit=0, max=den=0.
- FREE slot 2 and slot 5, then ALLOC -> addr=2; n_used_o goes 8->6->7. FREE of slot 2 again after it is freed -> upd_err_o pulse, n_used_o unchanged. UPDATE to addr 9 -> upd_err_o pulse.
- Same cycle: LOAD 3 and UPDATE 3 with den=32'h3F800000 -> response carries the old den 32'h40000000; the next LOAD 3 returns 32'h3F800000. Same cycle: ALLOC and FREE of slot 0 with slots 0..6 allocated -> ALLOC returns addr 7, and n_used_o stays 7.
- Backpressure: hold rsp_ready_i=0 for 3 cycles with req_valid_i=1 -> req_ready_o=0 and the response stays stable. Release -> one response per cycle with no loss and no duplication.
- clear_i while rsp_valid_o=1 and n_used_o=5 -> next cycle rsp_valid_o=0, n_used_o=0, empty_o=1, and a subsequent LOAD of any slot returns hit=0. Asynchronous rst_i pulse mid-stream -> all outputs immediately at their reset values.
